tl_buffer_2: RTL and testbench

TileLink-UL decoupling buffer placed directly upstream of the 64-bit width-adaptation stage on the 29-bit-address peripheral path. It registers the A channel toward the downstream stage and the D channel back toward the master, using an independent FIFO per channel. This breaks the combinational ready/valid/data paths between crossbar and width stage, at a fixed cost of one cycle per direction.

---
 rtl/tl_buffer_pkg.sv | 39 +++
 rtl/tl_buffer_2_queue.sv | 73 +++++++
 rtl/tl_buffer_2.sv | 118 +++++++++++
 tb/tb_tl_buffer_2.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_buffer_pkg.sv
// Shared TileLink-UL beat types and field widths for the tl_buffer_2 decoupling buffer.
package tl_buffer_pkg;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 64;
  localparam int SRC_W  = 6;
  localparam int MASK_W = DATA_W / 8;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [2:0]        size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [2:0]        size;
    logic [SRC_W-1:0]  source;
    logic              sink;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_d_t;

  localparam int TL_A_W = $bits(tl_a_t);
  localparam int TL_D_W = $bits(tl_d_t);

  // Pointer advance that wraps at an arbitrary (not necessarily power-of-two) depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/tl_buffer_2_queue.sv
// Single-clock FIFO with occupancy counter; one instance per TileLink channel.
// TL_BUFFER_PIPE_EN: a full queue also accepts a beat in the cycle it emits one.
module tl_queue
  import tl_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, empty, enq_fire, deq_fire;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign deq_valid = !empty;
  assign deq_fire  = deq_valid && deq_ready;
`ifdef TL_BUFFER_PIPE_EN
  assign enq_ready = !full || deq_fire;
`else
  assign enq_ready = !full;
`endif
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_data  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH));
    if (deq_fire) rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH));
    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count makes stale words unreachable.
  always_ff @(posedge clock) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_data;
  end

endmodule

// File: rtl/tl_buffer_2.sv
// TileLink-UL A/D decoupling buffer: one registered FIFO per channel, one cycle each way.
// TL_BUFFER_PIPE_EN lets a full queue accept while emitting (ready then depends on far-side ready).
module tl_buffer_2
  import tl_buffer_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  // master-side A
  input  logic              auto_in_a_valid,
  output logic              auto_in_a_ready,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [2:0]        auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0] auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  // master-side D
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [1:0]        auto_in_d_bits_param,
  output logic [2:0]        auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic              auto_in_d_bits_sink,
  output logic              auto_in_d_bits_denied,
  output logic [DATA_W-1:0] auto_in_d_bits_data,
  output logic              auto_in_d_bits_corrupt,
  // width-stage A
  input  logic              auto_out_a_ready,
  output logic              auto_out_a_valid,
  output logic [2:0]        auto_out_a_bits_opcode,
  output logic [2:0]        auto_out_a_bits_param,
  output logic [2:0]        auto_out_a_bits_size,
  output logic [SRC_W-1:0]  auto_out_a_bits_source,
  output logic [ADDR_W-1:0] auto_out_a_bits_address,
  output logic [MASK_W-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0] auto_out_a_bits_data,
  output logic              auto_out_a_bits_corrupt,
  // width-stage D
  input  logic              auto_out_d_valid,
  output logic              auto_out_d_ready,
  input  logic [2:0]        auto_out_d_bits_opcode,
  input  logic [1:0]        auto_out_d_bits_param,
  input  logic [2:0]        auto_out_d_bits_size,
  input  logic [SRC_W-1:0]  auto_out_d_bits_source,
  input  logic              auto_out_d_bits_sink,
  input  logic              auto_out_d_bits_denied,
  input  logic [DATA_W-1:0] auto_out_d_bits_data,
  input  logic              auto_out_d_bits_corrupt
);

  tl_a_t a_enq, a_deq;
  tl_d_t d_enq, d_deq;

  assign a_enq = '{opcode:  auto_in_a_bits_opcode,
                   param:   auto_in_a_bits_param,
                   size:    auto_in_a_bits_size,
                   source:  auto_in_a_bits_source,
                   address: auto_in_a_bits_address,
                   mask:    auto_in_a_bits_mask,
                   data:    auto_in_a_bits_data,
                   corrupt: auto_in_a_bits_corrupt};

  assign d_enq = '{opcode:  auto_out_d_bits_opcode,
                   param:   auto_out_d_bits_param,
                   size:    auto_out_d_bits_size,
                   source:  auto_out_d_bits_source,
                   sink:    auto_out_d_bits_sink,
                   denied:  auto_out_d_bits_denied,
                   data:    auto_out_d_bits_data,
                   corrupt: auto_out_d_bits_corrupt};

  tl_queue #(.WIDTH(TL_A_W), .DEPTH(A_DEPTH)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in_a_valid),
    .enq_ready (auto_in_a_ready),
    .enq_data  (a_enq),
    .deq_valid (auto_out_a_valid),
    .deq_ready (auto_out_a_ready),
    .deq_data  (a_deq)
  );

  tl_queue #(.WIDTH(TL_D_W), .DEPTH(D_DEPTH)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out_d_valid),
    .enq_ready (auto_out_d_ready),
    .enq_data  (d_enq),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_data  (d_deq)
  );

  assign auto_out_a_bits_opcode  = a_deq.opcode;
  assign auto_out_a_bits_param   = a_deq.param;
  assign auto_out_a_bits_size    = a_deq.size;
  assign auto_out_a_bits_source  = a_deq.source;
  assign auto_out_a_bits_address = a_deq.address;
  assign auto_out_a_bits_mask    = a_deq.mask;
  assign auto_out_a_bits_data    = a_deq.data;
  assign auto_out_a_bits_corrupt = a_deq.corrupt;

  assign auto_in_d_bits_opcode   = d_deq.opcode;
  assign auto_in_d_bits_param    = d_deq.param;
  assign auto_in_d_bits_size     = d_deq.size;
  assign auto_in_d_bits_source   = d_deq.source;
  assign auto_in_d_bits_sink     = d_deq.sink;
  assign auto_in_d_bits_denied   = d_deq.denied;
  assign auto_in_d_bits_data     = d_deq.data;
  assign auto_in_d_bits_corrupt  = d_deq.corrupt;

endmodule

// File: tb/tb_tl_buffer_2.sv
// Self-checking bench for tl_buffer_2: directed scenarios plus random traffic against queue models.
module tb_tl_buffer_2;
  import tl_buffer_pkg::*;

`ifdef TL_BUFFER_PIPE_EN
  localparam int A_DEPTH = 1;
  localparam int D_DEPTH = 1;
  localparam bit PIPE    = 1'b1;
`else
  localparam int A_DEPTH = 2;
  localparam int D_DEPTH = 2;
  localparam bit PIPE    = 1'b0;
`endif

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  logic  in_a_valid = 1'b0, out_a_ready = 1'b0, out_d_valid = 1'b0, in_d_ready = 1'b0;
  tl_a_t a_drv = '0;
  tl_d_t d_drv = '0;

  logic in_a_ready, out_a_valid, out_d_ready, in_d_valid;
  logic [2:0] oa_opcode, oa_param, oa_size, id_opcode, id_size;
  logic [1:0] id_param;
  logic [SRC_W-1:0] oa_source, id_source;
  logic [ADDR_W-1:0] oa_address;
  logic [MASK_W-1:0] oa_mask;
  logic [DATA_W-1:0] oa_data, id_data;
  logic oa_corrupt, id_sink, id_denied, id_corrupt;
  tl_a_t a_obs_w;
  tl_d_t d_obs_w;

  assign a_obs_w = '{opcode: oa_opcode, param: oa_param, size: oa_size, source: oa_source,
                     address: oa_address, mask: oa_mask, data: oa_data, corrupt: oa_corrupt};
  assign d_obs_w = '{opcode: id_opcode, param: id_param, size: id_size, source: id_source,
                     sink: id_sink, denied: id_denied, data: id_data, corrupt: id_corrupt};

  tl_buffer_2 #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(in_a_valid), .auto_in_a_ready(in_a_ready),
    .auto_in_a_bits_opcode(a_drv.opcode), .auto_in_a_bits_param(a_drv.param),
    .auto_in_a_bits_size(a_drv.size), .auto_in_a_bits_source(a_drv.source),
    .auto_in_a_bits_address(a_drv.address), .auto_in_a_bits_mask(a_drv.mask),
    .auto_in_a_bits_data(a_drv.data), .auto_in_a_bits_corrupt(a_drv.corrupt),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
    .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_param(id_param),
    .auto_in_d_bits_size(id_size), .auto_in_d_bits_source(id_source),
    .auto_in_d_bits_sink(id_sink), .auto_in_d_bits_denied(id_denied),
    .auto_in_d_bits_data(id_data), .auto_in_d_bits_corrupt(id_corrupt),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
    .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
    .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
    .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
    .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
    .auto_out_d_valid(out_d_valid), .auto_out_d_ready(out_d_ready),
    .auto_out_d_bits_opcode(d_drv.opcode), .auto_out_d_bits_param(d_drv.param),
    .auto_out_d_bits_size(d_drv.size), .auto_out_d_bits_source(d_drv.source),
    .auto_out_d_bits_sink(d_drv.sink), .auto_out_d_bits_denied(d_drv.denied),
    .auto_out_d_bits_data(d_drv.data), .auto_out_d_bits_corrupt(d_drv.corrupt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: plain FIFOs of beats plus logs of what the master/width stage received.
  tl_a_t a_model[$], a_log[$];
  tl_d_t d_model[$], d_log[$];

  logic  exp_oav, exp_iar, exp_idv, exp_odr;
  tl_a_t exp_oa;
  tl_d_t exp_id;
  logic  obs_oav, obs_iar, obs_idv, obs_odr;
  tl_a_t obs_oa;
  tl_d_t obs_id;
  logic  a_in_fire, a_out_fire, d_in_fire, d_out_fire;

  localparam tl_a_t IDLE_A = '0;
  localparam tl_d_t IDLE_D = '0;

  function automatic tl_a_t rand_a();
    tl_a_t b;
    b.opcode  = 3'($urandom);
    b.param   = 3'($urandom);
    b.size    = 3'($urandom);
    b.source  = SRC_W'($urandom);
    b.address = ADDR_W'($urandom);
    b.mask    = MASK_W'($urandom);
    b.data    = {$urandom, $urandom};
    b.corrupt = 1'($urandom);
    return b;
  endfunction

  function automatic tl_d_t rand_d();
    tl_d_t b;
    b.opcode  = 3'($urandom);
    b.param   = 2'($urandom);
    b.size    = 3'($urandom);
    b.source  = SRC_W'($urandom);
    b.sink    = 1'($urandom);
    b.denied  = 1'($urandom);
    b.data    = {$urandom, $urandom};
    b.corrupt = 1'($urandom);
    return b;
  endfunction

  // One clock cycle: drive at negedge, sample, derive model expectations and advance the model.
  task automatic step(input logic iav, input tl_a_t ia, input logic oar,
                      input logic odv, input tl_d_t od, input logic idr);
    @(negedge clock);
    in_a_valid = iav; a_drv = ia; out_a_ready = oar;
    out_d_valid = odv; d_drv = od; in_d_ready = idr;
    #1;
    exp_oav = (a_model.size() != 0);
    exp_oa  = exp_oav ? a_model[0] : IDLE_A;
    exp_iar = (a_model.size() < A_DEPTH) || (PIPE && exp_oav && oar);
    exp_idv = (d_model.size() != 0);
    exp_id  = exp_idv ? d_model[0] : IDLE_D;
    exp_odr = (d_model.size() < D_DEPTH) || (PIPE && exp_idv && idr);
    obs_oav = out_a_valid; obs_oa = a_obs_w; obs_iar = in_a_ready;
    obs_idv = in_d_valid;  obs_id = d_obs_w; obs_odr = out_d_ready;
    a_out_fire = exp_oav && oar;
    a_in_fire  = iav && exp_iar;
    d_out_fire = exp_idv && idr;
    d_in_fire  = odv && exp_odr;
    if (a_out_fire) a_log.push_back(a_model.pop_front());
    if (a_in_fire)  a_model.push_back(ia);
    if (d_out_fire) d_log.push_back(d_model.pop_front());
    if (d_in_fire)  d_model.push_back(od);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    in_a_valid = 1'b0; out_d_valid = 1'b0;
    a_model.delete(); d_model.delete();
  endtask

  task automatic test_reset();
    in_a_valid = 1'b0; out_a_ready = 1'b0; out_d_valid = 1'b0; in_d_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    step(1'b0, IDLE_A, 1'b1, 1'b0, IDLE_D, 1'b1);
    checks++; if (obs_oav !== 1'b0) begin errors++; $display("FAIL reset_out_a_valid: got %b want 0", obs_oav); end
    checks++; if (obs_idv !== 1'b0) begin errors++; $display("FAIL reset_in_d_valid: got %b want 0", obs_idv); end
    checks++; if (obs_iar !== 1'b1) begin errors++; $display("FAIL reset_in_a_ready: got %b want 1", obs_iar); end
    checks++; if (obs_odr !== 1'b1) begin errors++; $display("FAIL reset_out_d_ready: got %b want 1", obs_odr); end
  endtask

  task automatic test_single_get();
    tl_a_t get;
    get = '{opcode: 3'd4, param: 3'd0, size: 3'd3, source: 6'h15, address: 29'h1000_0040,
            mask: 8'hFF, data: {$urandom, $urandom}, corrupt: 1'b0};
    step(1'b1, get, 1'b1, 1'b0, IDLE_D, 1'b1);
    checks++; if (obs_oav !== 1'b0) begin errors++; $display("FAIL get_no_comb_path: got valid %b want 0", obs_oav); end
    checks++; if (obs_iar !== 1'b1) begin errors++; $display("FAIL get_accept: got ready %b want 1", obs_iar); end
    step(1'b0, IDLE_A, 1'b1, 1'b0, IDLE_D, 1'b1);
    checks++;
    if (obs_oav !== 1'b1 || obs_oa !== get) begin
      errors++; $display("FAIL get_out: got v=%b %h want v=1 %h", obs_oav, obs_oa, get);
    end
    step(1'b0, IDLE_A, 1'b1, 1'b0, IDLE_D, 1'b1);
    checks++; if (obs_oav !== 1'b0) begin errors++; $display("FAIL get_single: got valid %b want 0", obs_oav); end
  endtask

  task automatic test_backpressure();
    tl_a_t pend[$];
    int    accepted = 0;
    tl_a_t b;
    a_log.delete();
    for (int i = 0; i < 3; i++) begin
      b = rand_a(); b.data = 64'hA + 64'(i); pend.push_back(b);
    end
    for (int c = 0; c < 4; c++) begin
      step(pend.size() != 0, (pend.size() != 0) ? pend[0] : IDLE_A, 1'b0, 1'b0, IDLE_D, 1'b1);
      checks++;
      if (obs_oav !== exp_oav || obs_iar !== exp_iar || (exp_oav && obs_oa !== exp_oa)) begin
        errors++; $display("FAIL bp_hold c%0d: got v=%b r=%b %h want v=%b r=%b %h",
                           c, obs_oav, obs_iar, obs_oa, exp_oav, exp_iar, exp_oa);
      end
      if (a_in_fire) begin accepted++; void'(pend.pop_front()); end
    end
    checks++; if (accepted != A_DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", accepted, A_DEPTH); end
    checks++; if (obs_iar !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", obs_iar); end
    for (int c = 0; c < 12 && (pend.size() != 0 || a_model.size() != 0); c++) begin
      step(pend.size() != 0, (pend.size() != 0) ? pend[0] : IDLE_A, 1'b1, 1'b0, IDLE_D, 1'b1);
      checks++;
      if (obs_oav !== exp_oav || obs_iar !== exp_iar || (exp_oav && obs_oa !== exp_oa)) begin
        errors++; $display("FAIL bp_release c%0d: got v=%b r=%b %h want v=%b r=%b %h",
                           c, obs_oav, obs_iar, obs_oa, exp_oav, exp_iar, exp_oa);
      end
      if (a_in_fire) void'(pend.pop_front());
    end
    checks++; if (a_log.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", a_log.size()); end
    for (int i = 0; i < a_log.size(); i++) begin
      checks++;
      if (a_log[i].data !== 64'hA + 64'(i)) begin
        errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, a_log[i].data, 64'hA + 64'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    tl_a_t b;
    for (int c = 0; c <= 16; c++) begin
      b = rand_a(); b.data = 64'(c);
      step(c < 16, b, 1'b1, 1'b0, IDLE_D, 1'b1);
      if (c < 16) begin
        checks++; if (obs_iar !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d: got %b want 1", c, obs_iar); end
      end
      if (c >= 1) begin
        checks++;
        if (obs_oav !== 1'b1 || obs_oa.data !== 64'(c - 1) || obs_oa !== exp_oa) begin
          errors++; $display("FAIL stream_out c%0d: got v=%b data=%0h want v=1 data=%0h", c, obs_oav, obs_oa.data, c - 1);
        end
      end
    end
    step(1'b0, IDLE_A, 1'b1, 1'b0, IDLE_D, 1'b1);
    checks++; if (obs_oav !== 1'b0) begin errors++; $display("FAIL stream_drained: got valid %b want 0", obs_oav); end
  endtask

  task automatic test_d_response();
    tl_d_t sent[$], pend[$];
    tl_d_t b;
    d_log.delete();
    for (int i = 0; i < 24; i++) begin
      b = rand_d(); b.denied = 1'b1; b.corrupt = 1'b1; b.source = 6'h3F;
      sent.push_back(b); pend.push_back(b);
    end
    for (int c = 0; c < 400 && (pend.size() != 0 || d_model.size() != 0); c++) begin
      step(1'b0, IDLE_A, 1'($urandom),
           (pend.size() != 0) && ($urandom_range(0, 3) != 0), (pend.size() != 0) ? pend[0] : IDLE_D,
           (c > 300) ? 1'b1 : 1'($urandom));
      checks++;
      if (obs_idv !== exp_idv || obs_odr !== exp_odr || (exp_idv && obs_id !== exp_id) || obs_oav !== 1'b0) begin
        errors++; $display("FAIL d_resp c%0d: got v=%b r=%b %h av=%b want v=%b r=%b %h av=0",
                           c, obs_idv, obs_odr, obs_id, obs_oav, exp_idv, exp_odr, exp_id);
      end
      if (d_in_fire) void'(pend.pop_front());
    end
    checks++; if (d_log.size() != sent.size()) begin errors++; $display("FAIL d_resp_count: got %0d want %0d", d_log.size(), sent.size()); end
    for (int i = 0; i < d_log.size() && i < sent.size(); i++) begin
      checks++;
      if (d_log[i] !== sent[i]) begin errors++; $display("FAIL d_resp_beat[%0d]: got %h want %h", i, d_log[i], sent[i]); end
    end
  endtask

  task automatic test_random_both();
    for (int c = 0; c < 300; c++) begin
      step(1'($urandom), rand_a(), 1'($urandom), 1'($urandom), rand_d(), 1'($urandom));
      checks++;
      if (obs_oav !== exp_oav || obs_iar !== exp_iar || (exp_oav && obs_oa !== exp_oa) ||
          obs_idv !== exp_idv || obs_odr !== exp_odr || (exp_idv && obs_id !== exp_id)) begin
        errors++; $display("FAIL random c%0d: got a v=%b r=%b %h d v=%b r=%b %h want a v=%b r=%b %h d v=%b r=%b %h",
                           c, obs_oav, obs_iar, obs_oa, obs_idv, obs_odr, obs_id,
                           exp_oav, exp_iar, exp_oa, exp_idv, exp_odr, exp_id);
      end
    end
  endtask

  task automatic test_reset_mid_traffic();
    do_reset();
    for (int c = 0; c <= A_DEPTH; c++) step(1'b1, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0);
    @(negedge clock);
    reset = 1'b1; in_a_valid = 1'b1; a_drv = rand_a(); out_a_ready = 1'b1;
    out_d_valid = 1'b1; in_d_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0; in_a_valid = 1'b0; out_d_valid = 1'b0;
    a_model.delete(); d_model.delete();
    #1;
    checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_a_valid: got %b want 0", out_a_valid); end
    checks++; if (in_a_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_a_ready: got %b want 1", in_a_ready); end
    checks++; if (in_d_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_in_d_valid: got %b want 0", in_d_valid); end
    for (int c = 0; c < 4; c++) begin
      step(1'b0, IDLE_A, 1'b1, 1'b0, IDLE_D, 1'b1);
      checks++;
      if (obs_oav !== 1'b0 || obs_idv !== 1'b0) begin
        errors++; $display("FAIL rst_mid_no_emit c%0d: got a=%b d=%b want 0 0", c, obs_oav, obs_idv);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_get();
    test_backpressure();
    test_back_to_back();
    test_d_response();
    test_random_both();
    test_reset_mid_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
